fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end: owns the fetch PC, issues one
//  ibus request at a time, and buffers returned instructions in a DEPTH-entry
//  FIFO so decode stalls do not stall the ibus. Supports redirect (branch/
//  exception) with discard of the in-flight response. Sits between the ibus
//  arbiter and decode; its output is a fetch_data_t stream with valid/ready.
// PARAMETERS
//  DEPTH     4              FIFO entries (power of two, >=2)
//  PC_RESET  64'h8000_0000  first fetch address after reset
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous reset, active-low
//  ibus_valid     out  1   ibus request valid
//  ibus_addr      out  64  ibus request address (word aligned)
//  ibus_data_ok   in   1   response valid this cycle, completes the request
//  ibus_data      in   32  returned instruction
//  redirect       in   1   flush queue and restart fetch at redirect_pc
//  redirect_pc    in   64  new fetch PC (bits[1:0] ignored, forced to 0)
//  out_ready      in   1   decode accepts head entry
//  out_data       out  -   fetch_data_t {valid, pc, raw_instr} of FIFO head
// BEHAVIOUR
//  - Reset (reset=0, async): pc=PC_RESET, FIFO empty, count=0, state=IDLE,
//    ibus_valid=0, ibus_addr=0, out_data='0. Reset mid-request drops it.
//  - FSM IDLE->REQ when count<DEPTH and !redirect: assert ibus_valid,
//    ibus_addr=pc. REQ: hold valid and addr stable until ibus_data_ok.
//    On data_ok: push {pc,ibus_data}, pc+=4, then REQ again if a slot
//    remains after the push (count incl. this push <DEPTH, counting a same-
//    cycle pop), else IDLE. Max one outstanding request.
//  - Redirect in REQ without data_ok: request cannot be withdrawn -> DROP;
//    keep ibus_valid/ibus_addr unchanged; on data_ok discard data, -> IDLE.
//  - Redirect same cycle as data_ok (REQ or DROP): data discarded -> IDLE.
//  - Any redirect: FIFO cleared next cycle, pc<=redirect_pc&~3; flush wins
//    over same-cycle push/pop; out_data.valid=0 the following cycle; new
//    request issued no earlier than the cycle after redirect.
//  - Redirect in DROP: latest redirect_pc wins; stay in DROP.
//  - Output: out_data.valid = !empty; pc/raw_instr from head; pop when
//    valid&&out_ready. Data pushed at edge T visible at cycle T+1.
//  - Full: no new request; simultaneous push+pop at count==DEPTH-1 legal.
//    Pop on empty ignored. Pointers log2(DEPTH) bits, wrap naturally;
//    count is log2(DEPTH)+1 bits.
//  - out_data.pc/raw_instr hold last head value when invalid (don't-care).
// STRUCTURE
//  - pipes package: fetch_data_t (existing), fetch_state_t enum
//    {IDLE,REQ,DROP}. common package: u32/u64, PC_RESET default constant.
//  - One sub-module: fetch_fifo (DEPTH, payload fetch_data_t, push/pop/
//    flush, full/empty/count); fetch_queue holds FSM, PC and ibus logic.
// TESTING
//  - Reset release, ibus replies data_ok 1 cycle after each request, ready=1
//    -> addrs 8000_0000,_0004,_0008 in order; out pcs match, no gaps.
//  - out_ready=0, DEPTH=4 -> exactly 4 requests, ibus_valid then 0, count=4;
//    raise ready -> 4 pops in order, fetch resumes at 8000_0010.
//  - Redirect to 8000_1002 while REQ pending 3 cycles -> ibus_addr held,
//    reply discarded, out valid=0, next request addr 8000_1000.
//  - Redirect coincident with data_ok and a pop -> FIFO empty next cycle,
//    that data never appears at output.
//  - Two redirects during DROP (A then B) -> first post-drop request is B.
//  - Assert reset mid-REQ with 2 entries queued -> all outputs zero
//    immediately; after release first ibus_addr=PC_RESET.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: scalar aliases, the
// decode-facing fetch record and the fetch FSM state encoding.
package fetch_queue_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64 PC_RESET_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry buffer of fetched {pc, instr} pairs; flush has priority over
// push/pop, and the head is presented combinationally from the read pointer.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [63:0]            push_pc,
    input  logic [31:0]            push_instr,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_data_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [63:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full buffer is only accepted when a pop frees the slot.
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage is cleared on reset so the idle output reads as all zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push_ok && !flush) begin
            pc_mem[wr_ptr_reg]    <= push_pc;
            instr_mem[wr_ptr_reg] <= push_instr;
        end
    end

    always_comb begin
        head           = '0;
        head.valid     = !empty;
        head.pc        = pc_mem[rd_ptr_reg];
        head.raw_instr = instr_mem[rd_ptr_reg];
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, keeps at most one ibus request in
// flight and buffers replies for decode; redirects discard in-flight data.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ibus_valid,
    output logic [63:0] ibus_addr,
    input  logic        ibus_data_ok,
    input  logic [31:0] ibus_data,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        out_ready,
    output fetch_data_t out_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state_reg;
    fetch_state_t     state_next;
    logic [63:0]      pc_reg;
    logic [63:0]      pc_next;
    logic [63:0]      addr_reg;
    logic [63:0]      addr_next;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_after;
    logic             pop_fire;

    assign pop_fire  = out_ready && !fifo_empty;
    assign ibus_addr = addr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= PC_RESET;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        addr_next   = addr_reg;
        // Occupancy once this cycle's reply is pushed and any pop retires.
        count_after = fifo_count + CNT_W'(1) - CNT_W'(pop_fire);
        unique case (state_reg)
            IDLE: begin
                if (!redirect && !fifo_full) begin
                    state_next = REQ;
                    addr_next  = pc_reg;
                end
            end
            REQ: begin
                if (ibus_data_ok) begin
                    if (redirect) begin
                        state_next = IDLE;
                    end else begin
                        pc_next = pc_reg + 64'd4;
                        if (count_after < CNT_W'(DEPTH)) begin
                            state_next = REQ;
                            addr_next  = pc_reg + 64'd4;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end else if (redirect) begin
                    // The bus cannot cancel a request; wait out its reply.
                    state_next = DROP;
                end
            end
            DROP: begin
                if (ibus_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            pc_next = redirect_pc & ~64'h3;
        end
    end

    always_comb begin
        ibus_valid = (state_reg != IDLE);
        fifo_push  = (state_reg == REQ) && ibus_data_ok && !redirect;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_pc    (addr_reg),
        .push_instr (ibus_data),
        .pop        (out_ready),
        .flush      (redirect),
        .head       (out_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an ibus responder model feeds a scoreboard
// of expected fetch records, checked as decode pops them.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] PC_RST = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibus_valid;
    logic [63:0] ibus_addr;
    logic        ibus_data_ok = 1'b0;
    logic [31:0] ibus_data = '0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    fetch_data_t out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .PC_RESET (PC_RST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ibus_valid   (ibus_valid),
        .ibus_addr    (ibus_addr),
        .ibus_data_ok (ibus_data_ok),
        .ibus_data    (ibus_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] req_log[$];
    logic        in_req = 1'b0;
    logic        stale = 1'b0;
    logic        resp_en = 1'b0;
    logic        arm_redir = 1'b0;
    logic [63:0] arm_pc = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] exp_next = PC_RST;
    int          resp_delay = 1;
    int          req_age = 0;
    int          pop_cnt = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {a[15:0] ^ 16'h1357, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b0;
        ibus_data_ok = 1'b0;
        redirect     = 1'b0;
        #1;
        check("rst_ibus_valid", ibus_valid, 1'b0);
        check("rst_ibus_addr", ibus_addr, 64'h0);
        check("rst_out_data", 128'(out_data), 128'h0);
        sb.delete();
        req_log.delete();
        in_req    = 1'b0;
        stale     = 1'b0;
        arm_redir = 1'b0;
        exp_next  = PC_RST;
        pop_cnt   = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // One clock cycle: observe outputs, drive responder, update model, advance.
    task automatic tick();
        exp_t e;
        if (in_req) begin
            check("req_hold_valid", ibus_valid, 1'b1);
            check("req_hold_addr", ibus_addr, req_addr);
        end else if (ibus_valid) begin
            in_req   = 1'b1;
            req_addr = ibus_addr;
            req_age  = 0;
            req_log.push_back(ibus_addr);
            check("req_addr", ibus_addr, exp_next);
        end
        ibus_data_ok = 1'b0;
        if (in_req && resp_en && req_age >= resp_delay) begin
            ibus_data_ok = 1'b1;
            ibus_data    = instr_of(req_addr);
        end
        if (arm_redir && ibus_data_ok) begin
            redirect    = 1'b1;
            redirect_pc = arm_pc;
            out_ready   = 1'b1;
            arm_redir   = 1'b0;
        end
        if (out_data.valid && out_ready && !redirect) begin
            pop_cnt++;
            if (sb.size() == 0) begin
                check("out_valid_unexpected", out_data.valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("out_pc", out_data.pc, e.pc);
                check("out_instr", out_data.raw_instr, e.instr);
            end
        end
        if (ibus_data_ok) begin
            if (!stale && !redirect) begin
                e.pc    = req_addr;
                e.instr = instr_of(req_addr);
                sb.push_back(e);
                exp_next = req_addr + 64'd4;
            end
            in_req = 1'b0;
            stale  = 1'b0;
        end else if (in_req && redirect) begin
            stale = 1'b1;
        end
        if (redirect) begin
            sb.delete();
            exp_next = redirect_pc & ~64'h3;
        end
        @(posedge clk); #1;
        req_age++;
        redirect     = 1'b0;
        ibus_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        // Streaming fetch with decode always ready.
        apply_reset();
        out_ready  = 1'b1;
        resp_en    = 1'b1;
        resp_delay = 1;
        repeat (14) tick();
        check("t1_req_count", req_log.size(), 7);
        check("t1_addr0", req_log[0], 64'h8000_0000);
        check("t1_addr1", req_log[1], 64'h8000_0004);
        check("t1_addr2", req_log[2], 64'h8000_0008);
        check("t1_pop_count", pop_cnt, 6);
        $display("t1 stream: reqs=%0d pops=%0d", req_log.size(), pop_cnt);

        // Decode stalled: queue fills, then drains in order.
        apply_reset();
        out_ready = 1'b0;
        resp_en   = 1'b1;
        repeat (20) tick();
        check("t2_req_count", req_log.size(), 4);
        check("t2_ibus_idle", ibus_valid, 1'b0);
        check("t2_head_valid", out_data.valid, 1'b1);
        check("t2_sb_entries", sb.size(), 4);
        out_ready = 1'b1;
        repeat (12) tick();
        check("t2_resume_addr", req_log[4], 64'h8000_0010);
        $display("t2 full/drain: reqs=%0d pops=%0d", req_log.size(), pop_cnt);

        // Redirect while a request is pending.
        apply_reset();
        out_ready = 1'b0;
        resp_en   = 1'b0;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_1002;
        tick();
        repeat (3) tick();
        resp_en = 1'b1;
        tick();
        check("t3_out_invalid", out_data.valid, 1'b0);
        check("t3_ibus_idle", ibus_valid, 1'b0);
        repeat (2) tick();
        check("t3_new_addr", req_log[1], 64'h8000_1000);
        out_ready = 1'b1;
        repeat (6) tick();
        $display("t3 redirect pending: reqs=%0d pops=%0d", req_log.size(), pop_cnt);

        // Redirect coincident with a reply and a pop.
        apply_reset();
        out_ready = 1'b0;
        resp_en   = 1'b1;
        for (int i = 0; i < 10 && sb.size() < 2; i++) tick();
        check("t4_sb_entries", sb.size(), 2);
        arm_redir = 1'b1;
        arm_pc    = 64'h8000_4000;
        for (int i = 0; i < 8 && arm_redir; i++) tick();
        check("t4_redir_fired", arm_redir, 1'b0);
        check("t4_out_invalid", out_data.valid, 1'b0);
        check("t4_ibus_idle", ibus_valid, 1'b0);
        repeat (8) tick();
        check("t4_new_addr", req_log[3], 64'h8000_4000);
        $display("t4 redirect+reply: reqs=%0d pops=%0d", req_log.size(), pop_cnt);

        // Two redirects while dropping: the later target wins.
        apply_reset();
        out_ready = 1'b1;
        resp_en   = 1'b0;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_2000;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_3000;
        tick();
        tick();
        resp_en = 1'b1;
        repeat (4) tick();
        check("t5_new_addr", req_log[1], 64'h8000_3000);
        $display("t5 double redirect: reqs=%0d pops=%0d", req_log.size(), pop_cnt);

        // Reset while a request is in flight with entries queued.
        apply_reset();
        out_ready = 1'b0;
        resp_en   = 1'b1;
        for (int i = 0; i < 12 && !(sb.size() == 2 && in_req); i++) tick();
        check("t6_sb_entries", sb.size(), 2);
        check("t6_in_req", ibus_valid, 1'b1);
        apply_reset();
        out_ready = 1'b1;
        resp_en   = 1'b1;
        repeat (4) tick();
        check("t6_first_addr", req_log[0], PC_RST);
        $display("t6 mid-request reset: reqs=%0d pops=%0d", req_log.size(), pop_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
